// File: rtl/afvip_rst_pkg.sv
// Shared types and default constants for the reset generator.
package afvip_rst_pkg;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_LEN_W       = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_POR_CYCLES  = 16;

    typedef enum logic [1:0] {
        CH_POR    = 2'd0,
        CH_IDLE   = 2'd1,
        CH_ASSERT = 2'd2
    } ch_state_e;

    // Channel index width carries one spare bit so out-of-range indices are representable.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return ((n > 1) ? int'($clog2(n)) : 1) + 1;
    endfunction

endpackage

// File: rtl/afvip_rst_gen_if.sv
// Reset-request handshake between a requester and afvip_rst_gen.
interface afvip_rst_gen_if
    import afvip_rst_pkg::*;
#(
    parameter int unsigned CH_W  = ch_idx_w(DEF_NUM_CH),
    parameter int unsigned LEN_W = DEF_LEN_W
);
    logic             req_valid;
    logic             req_ready;
    logic [CH_W-1:0]  req_ch;
    logic             req_all;
    logic [LEN_W-1:0] req_len;

    modport master (
        output req_valid, req_ch, req_all, req_len,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_ch, req_all, req_len,
        output req_ready
    );
endinterface

// File: rtl/afvip_rst_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchroniser.
module afvip_rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/afvip_rst_gen.sv
// Multi-channel reset generator: power-on hold followed by per-channel timed
// reset pulses requested over a valid/ready handshake.
module afvip_rst_gen
    import afvip_rst_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned POR_CYCLES  = DEF_POR_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    afvip_rst_gen_if.slave     req,
    output logic [NUM_CH-1:0]  ch_rst_n,
    output logic [NUM_CH-1:0]  ch_busy,
    output logic [NUM_CH-1:0]  done_pulse,
    output logic               req_err
);

    localparam int unsigned CH_W  = ch_idx_w(NUM_CH);
    localparam int unsigned POR_W = $clog2(POR_CYCLES + 1);

    logic              rst_sync_n;
    logic              por_active;
    logic [POR_W-1:0]  por_cnt;
    logic              por_release;
    logic              req_oor;
    logic              ready_c;
    logic              accept;
    logic [NUM_CH-1:0] target;
    logic [NUM_CH-1:0] ch_por;
    logic [NUM_CH-1:0] ch_idle;
    logic [LEN_W-1:0]  load_len;

    afvip_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    // Shared power-on hold counter, started once the synchronised release arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            por_active <= 1'b1;
            por_cnt    <= '0;
        end else if (por_active && rst_sync_n) begin
            if (por_cnt == POR_W'(POR_CYCLES - 1)) begin
                por_active <= 1'b0;
            end else begin
                por_cnt <= por_cnt + POR_W'(1);
            end
        end
    end

    assign por_release = por_active && rst_sync_n && (por_cnt == POR_W'(POR_CYCLES - 1));

    // Request decode: target mask, out-of-range detection, and zero-length clamp.
    always_comb begin
        req_oor  = !req.req_all && (req.req_ch >= CH_W'(NUM_CH));
        target   = '0;
        if (req.req_all) begin
            target = '1;
        end else if (!req_oor) begin
            target = NUM_CH'(1) << req.req_ch;
        end
        load_len = (req.req_len == '0) ? LEN_W'(1) : req.req_len;
    end

    assign ready_c       = !(|ch_por) && (req_oor || ((target & ~ch_idle) == '0));
    assign req.req_ready = ready_c;
    assign accept        = req.req_valid && ready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_err <= 1'b0;
        end else begin
            req_err <= accept && req_oor;
        end
    end

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        ch_state_e        state;
        logic [LEN_W-1:0] cnt;
        logic             rst_q;
        logic             busy_q;
        logic             done_q;

        // Per-channel POR -> IDLE -> ASSERT -> IDLE sequencer with registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= CH_POR;
                cnt    <= '0;
                rst_q  <= 1'b0;
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end else begin
                done_q <= 1'b0;
                case (state)
                    CH_POR: begin
                        if (por_release) begin
                            state  <= CH_IDLE;
                            rst_q  <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    CH_IDLE: begin
                        if (accept && target[i]) begin
                            state  <= CH_ASSERT;
                            cnt    <= load_len;
                            rst_q  <= 1'b0;
                            busy_q <= 1'b1;
                        end
                    end
                    CH_ASSERT: begin
                        if (cnt <= LEN_W'(1)) begin
                            state  <= CH_IDLE;
                            cnt    <= '0;
                            rst_q  <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            cnt <= cnt - LEN_W'(1);
                        end
                    end
                    default: begin
                        state <= CH_POR;
                    end
                endcase
            end
        end

        assign ch_rst_n[i]   = rst_q;
        assign ch_busy[i]    = busy_q;
        assign done_pulse[i] = done_q;
        assign ch_por[i]     = (state == CH_POR);
        assign ch_idle[i]    = (state == CH_IDLE);
    end

endmodule

// File: tb/tb_afvip_rst_gen.sv
// Self-checking bench for afvip_rst_gen: vector table plus POR, blocking and
// mid-assert reset sequences, checked against a queue of expected pulses.
module tb_afvip_rst_gen;
    import afvip_rst_pkg::*;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CH_W = ch_idx_w(NCH);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            all;
        logic [7:0]      len;
        logic [3:0]      mask;
        int              cycles;
        logic            err;
    } vec_t;

    typedef struct packed {
        logic [3:0] mask;
        int         cycles;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] ch_rst_n, ch_busy, done_pulse;
    logic req_err;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t sb[$];
    vec_t vecs[9];

    afvip_rst_gen_if #(.CH_W(CH_W), .LEN_W(8)) bus ();

    afvip_rst_gen #(
        .NUM_CH      (NCH),
        .LEN_W       (8),
        .SYNC_STAGES (2),
        .POR_CYCLES  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (bus.slave),
        .ch_rst_n   (ch_rst_n),
        .ch_busy    (ch_busy),
        .done_pulse (done_pulse),
        .req_err    (req_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Power-on sequence counted from the first edge after rst_n rises.
    task automatic por_check();
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e < 18) begin
                chk("por_hold_rst", ch_rst_n, 4'h0);
                chk("por_hold_ready", bus.req_ready, 1'b0);
            end else if (e == 18) begin
                chk("por_release_rst", ch_rst_n, 4'hF);
                chk("por_release_busy", ch_busy, 4'h0);
                chk("por_release_done", done_pulse, 4'hF);
                chk("por_release_ready", bus.req_ready, 1'b1);
            end else begin
                chk("por_done_single", done_pulse, 4'h0);
            end
        end
    endtask

    // Called at the first falling edge after the accepting edge.
    task automatic verify();
        exp_t e;
        logic [3:0] nm;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e  = sb.pop_front();
        nm = ~e.mask;
        if (e.cycles == 0) begin
            chk("err_pulse", req_err, e.err);
            chk("oor_rst", ch_rst_n, 4'hF);
            chk("oor_busy", ch_busy, 4'h0);
            @(negedge clk);
            chk("err_single", req_err, 1'b0);
            chk("oor_rst_after", ch_rst_n, 4'hF);
        end else begin
            for (int k = 1; k <= e.cycles; k++) begin
                if (k > 1) @(negedge clk);
                chk("assert_rst", ch_rst_n, nm);
                chk("assert_busy", ch_busy, e.mask);
                chk("assert_no_done", done_pulse, 4'h0);
                if (k == 1) chk("err_quiet", req_err, 1'b0);
            end
            @(negedge clk);
            chk("release_rst", ch_rst_n, 4'hF);
            chk("release_busy", ch_busy, 4'h0);
            chk("release_done", done_pulse, e.mask);
            @(negedge clk);
            chk("done_single", done_pulse, 4'h0);
        end
    endtask

    task automatic send(input vec_t v);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_ch    = v.ch;
        bus.req_all   = v.all;
        bus.req_len   = v.len;
        #1;
        chk("ready_idle", bus.req_ready, 1'b1);
        sb.push_back('{mask: v.mask, cycles: v.cycles, err: v.err});
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_all   = 1'b0;
        verify();
    endtask

    initial begin
        int waited;

        vecs[0] = '{ch: 3'd2, all: 1'b0, len: 8'd5,   mask: 4'b0100, cycles: 5,   err: 1'b0};
        vecs[1] = '{ch: 3'd0, all: 1'b0, len: 8'd0,   mask: 4'b0001, cycles: 1,   err: 1'b0};
        vecs[2] = '{ch: 3'd3, all: 1'b0, len: 8'd1,   mask: 4'b1000, cycles: 1,   err: 1'b0};
        vecs[3] = '{ch: 3'd1, all: 1'b0, len: 8'd3,   mask: 4'b0010, cycles: 3,   err: 1'b0};
        vecs[4] = '{ch: 3'd0, all: 1'b1, len: 8'd4,   mask: 4'b1111, cycles: 4,   err: 1'b0};
        vecs[5] = '{ch: 3'd5, all: 1'b0, len: 8'd7,   mask: 4'b0000, cycles: 0,   err: 1'b1};
        vecs[6] = '{ch: 3'd7, all: 1'b0, len: 8'd9,   mask: 4'b0000, cycles: 0,   err: 1'b1};
        vecs[7] = '{ch: 3'd5, all: 1'b1, len: 8'd2,   mask: 4'b1111, cycles: 2,   err: 1'b0};
        vecs[8] = '{ch: 3'd0, all: 1'b0, len: 8'd255, mask: 4'b0001, cycles: 255, err: 1'b0};

        bus.req_valid = 1'b0;
        bus.req_ch    = '0;
        bus.req_all   = 1'b0;
        bus.req_len   = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rst", ch_rst_n, 4'h0);
        chk("reset_busy", ch_busy, 4'hF);
        chk("reset_done", done_pulse, 4'h0);
        chk("reset_err", req_err, 1'b0);
        chk("reset_ready", bus.req_ready, 1'b0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        por_check();

        foreach (vecs[i]) send(vecs[i]);

        // req_all blocked while ch1 asserts, then all channels pulse together.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_ch    = 3'd1;
        bus.req_all   = 1'b0;
        bus.req_len   = 8'd6;
        #1 chk("blk_ready_ch1", bus.req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.req_all = 1'b1;
        bus.req_len = 8'd3;
        #1;
        chk("blk_ready_low", bus.req_ready, 1'b0);
        chk("blk_ch1_asserted", ch_rst_n, 4'b1101);
        waited = 0;
        while (!bus.req_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("blk_wait_cycles", waited, 6);
        chk("blk_ready_with_done", done_pulse, 4'b0010);
        sb.push_back('{mask: 4'hF, cycles: 3, err: 1'b0});
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_all   = 1'b0;
        verify();

        // Reset asserted in the middle of a long assertion on ch0.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_ch    = 3'd0;
        bus.req_len   = 8'd100;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_ch0_asserted", ch_rst_n, 4'b1110);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_abort_rst", ch_rst_n, 4'h0);
        chk("mid_abort_busy", ch_busy, 4'hF);
        chk("mid_abort_ready", bus.req_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        por_check();

        send(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
